decode_stage: RTL and testbench

- RV32I subset decode stage. Contains the IF/ID pipeline register, the 32x32 register file, the main/ALU control decoder and the immediate extender.
- Consumes fetch outputs (instruction, PC, PC+4) and writeback results.
- Produces every D-suffixed signal that the ID/EX register captures on the next clock.
- Hazard unit drives StallD/FlushD.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/register_file.sv | 36 +++
 rtl/decode_stage.sv | 135 +++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, control encodings and the pipeline bubble.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // sub_ok is only set for R-type; I-ALU uses bit 30 as immediate, not as a sub select.
    function automatic alu_ctl_e alu_dec(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/hazard/writeback inputs and ID/EX-bound outputs of the decode stage.
// IllegalD/IllegalSeen exist only when ILLEGAL_OPCODE_EN is defined.
interface decode_stage_if;
    import riscv_pkg::*;

    logic            StallD, FlushD;
    logic [XLEN-1:0] InstrF, PCF, PCplus4F;
    logic            RegWriteW;
    logic [4:0]      rdW;
    logic [XLEN-1:0] ResultW;

    logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [2:0]      ALUControlD;
    logic [1:0]      ResultSrcD, ImmSrcD;
    logic [4:0]      rdD, rs1D, rs2D;
    logic [XLEN-1:0] RD1D, RD2D, PCD, PCplus4D, ImmExtD;
`ifdef ILLEGAL_OPCODE_EN
    logic            IllegalD, IllegalSeen;
`endif

    modport master (
        output StallD, FlushD, InstrF, PCF, PCplus4F, RegWriteW, rdW, ResultW,
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD,
        input  ResultSrcD, ImmSrcD, rdD, rs1D, rs2D, RD1D, RD2D, PCD, PCplus4D,
        input  ImmExtD
`ifdef ILLEGAL_OPCODE_EN
        , input IllegalD, IllegalSeen
`endif
    );

    modport slave (
        input  StallD, FlushD, InstrF, PCF, PCplus4F, RegWriteW, rdW, ResultW,
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD,
        output ResultSrcD, ImmSrcD, rdD, rs1D, rs2D, RD1D, RD2D, PCD, PCplus4D,
        output ImmExtD
`ifdef ILLEGAL_OPCODE_EN
        , output IllegalD, IllegalSeen
`endif
    );

endinterface

// File: rtl/register_file.sv
// 2R1W register file; x0 hardwired to zero, same-cycle write-through on both read ports.
module register_file
    import riscv_pkg::*;
#(
    parameter  int W  = XLEN,
    parameter  int N  = NREGS,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2
);

    logic [W-1:0] regs [N];
    logic         wr_ok;

    assign wr_ok = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : (wr_ok && wa == ra1) ? wd : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (wr_ok && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, control decoder, immediate extender.
// Define ILLEGAL_OPCODE_EN to add IllegalD and the sticky IllegalSeen flag.
module decode_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave d
);

    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d, pc4_d;

    // Flush outranks stall so a squashed slot never sticks around.
    always_ff @(posedge clk) begin
        if (reset || d.FlushD) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            pc4_d   <= '0;
        end else if (!d.StallD) begin
            instr_d <= d.InstrF;
            pc_d    <= d.PCF;
            pc4_d   <= d.PCplus4F;
        end
    end

    logic [6:0] opcode;
    assign opcode = instr_d[6:0];

    register_file u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (d.RegWriteW),
        .wa    (d.rdW),
        .wd    (d.ResultW),
        .ra1   (instr_d[19:15]),
        .ra2   (instr_d[24:20]),
        .rd1   (d.RD1D),
        .rd2   (d.RD2D)
    );

    logic     reg_write, mem_write, jump, branch, alu_src;
    alu_ctl_e alu_ctl;
    res_src_e res_src;
    imm_src_e imm_src;

    always_comb begin
        reg_write = 1'b0;
        mem_write = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        alu_src   = 1'b0;
        alu_ctl   = ALU_ADD;
        res_src   = RES_ALU;
        imm_src   = IMM_I;
        case (opcode)
            OP_LW: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                res_src   = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_ctl   = alu_dec(instr_d[14:12], instr_d[30]);
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = alu_dec(instr_d[14:12], 1'b0);
            end
            OP_BEQ: begin
                branch    = 1'b1;
                imm_src   = IMM_B;
                alu_ctl   = ALU_SUB;
            end
            OP_JAL: begin
                jump      = 1'b1;
                reg_write = 1'b1;
                imm_src   = IMM_J;
                res_src   = RES_PC4;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S: imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B: imm_ext = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                              instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_J: imm_ext = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                              instr_d[20], instr_d[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    assign d.RegWriteD   = reg_write;
    assign d.MemWriteD   = mem_write;
    assign d.JumpD       = jump;
    assign d.BranchD     = branch;
    assign d.ALUSrcD     = alu_src;
    assign d.ALUControlD = alu_ctl;
    assign d.ResultSrcD  = res_src;
    assign d.ImmSrcD     = imm_src;
    assign d.rdD         = instr_d[11:7];
    assign d.rs1D        = instr_d[19:15];
    assign d.rs2D        = instr_d[24:20];
    assign d.PCD         = pc_d;
    assign d.PCplus4D    = pc4_d;
    assign d.ImmExtD     = imm_ext;

`ifdef ILLEGAL_OPCODE_EN
    logic illegal, illegal_seen;

    assign illegal = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});

    always_ff @(posedge clk) begin
        if (reset)        illegal_seen <= 1'b0;
        else if (illegal) illegal_seen <= 1'b1;
    end

    assign d.IllegalD    = illegal;
    assign d.IllegalSeen = illegal_seen;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decode records queued at drive time, checked one edge later.
module tb_decode_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .reset(reset), .d(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [11:0] ctrl;
        logic [14:0] regs;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    // ctrl = {RegWrite, MemWrite, Jump, Branch, ALUSrc, ALUControl, ResultSrc, ImmSrc}
    function automatic logic [11:0] c(input logic rw, mw, j, b, as,
                                      input logic [2:0] alu, input logic [1:0] rs, is);
        return {rw, mw, j, b, as, alu, rs, is};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [11:0] ctrl,
                                input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        exp_t e;
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.ctrl = ctrl;
        e.regs = {rd, rs1, rs2};
        e.imm  = imm;
        return e;
    endfunction

    function automatic exp_t nop_exp();
        exp_t e;
        e      = mk(32'h0, c(1, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00), 5'd0, 5'd0, 5'd0, 32'h0);
        e.pc4  = 32'h0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [31:0] pc);
        bus.InstrF   = instr;
        bus.PCF      = pc;
        bus.PCplus4F = pc + 32'd4;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        set_in(instr, pc);
        q.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_pc"},   {bus.PCD, bus.PCplus4D}, {e.pc, e.pc4});
            chk({tag, "_ctrl"}, 64'(({bus.RegWriteD, bus.MemWriteD, bus.JumpD, bus.BranchD,
                                      bus.ALUSrcD, bus.ALUControlD, bus.ResultSrcD,
                                      bus.ImmSrcD})), 64'(e.ctrl));
            chk({tag, "_regs"}, 64'({bus.rdD, bus.rs1D, bus.rs2D}), 64'(e.regs));
            chk({tag, "_imm"},  64'(bus.ImmExtD), 64'(e.imm));
        end
    endtask

    localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] ADD_X3  = 32'h0001_8233;
    localparam logic [31:0] ORI_M1  = 32'hFFF0_E093;
    localparam logic [31:0] ADDI_NG = 32'hC000_0093;
    localparam logic [31:0] SUB_I   = 32'h4031_00B3;
    localparam logic [31:0] SLT_I   = 32'h0020_A233;
    localparam logic [31:0] AND_I   = 32'h0031_70B3;
    localparam logic [31:0] BEQ_M4  = 32'hFE00_0EE3;
    localparam logic [31:0] JAL_0   = 32'h0000_006F;
    localparam logic [31:0] BAD_OP  = 32'h0000_007F;
    localparam logic [31:0] SW_I    = 32'h0051_2423;

    function automatic exp_t add_exp(input logic [31:0] pc);
        return mk(pc, c(1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00), 5'd4, 5'd3, 5'd0, 32'h0);
    endfunction

    initial begin
        reset         = 1'b1;
        bus.StallD    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.RegWriteW = 1'b0;
        bus.rdW       = 5'd0;
        bus.ResultW   = 32'h0;

        // Reset outranks a valid fetch.
        drive(ADDI_X1, 32'h100, nop_exp());
        tick("reset");
        chk("reset_rd1", 64'(bus.RD1D), 64'h0);
        reset = 1'b0;

        drive(ADDI_X1, 32'h100, mk(32'h100, c(1, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00),
                                   5'd1, 5'd0, 5'd5, 32'd5));
        tick("addi");

        drive(ADD_X3, 32'h104, add_exp(32'h104));
        tick("add");

        // Write-through on rs1=x3 while the stage stalls on the add.
        bus.StallD    = 1'b1;
        set_in(ORI_M1, 32'h200);
        bus.RegWriteW = 1'b1;
        bus.rdW       = 5'd3;
        bus.ResultW   = 32'hDEAD_BEEF;
        #1;
        chk("wt_rd1", 64'(bus.RD1D), 64'hDEAD_BEEF);
        q.push_back(add_exp(32'h104));
        tick("stall1");
        bus.rdW     = 5'd0;
        bus.ResultW = 32'h7;
        #1;
        chk("x3_held", 64'(bus.RD1D), 64'hDEAD_BEEF);
        chk("x0_bypass", 64'(bus.RD2D), 64'h0);
        set_in(SUB_I, 32'h300);
        q.push_back(add_exp(32'h104));
        tick("stall2");
        bus.RegWriteW = 1'b0;
        #1;
        chk("x0_write", 64'(bus.RD2D), 64'h0);
        chk("x3_store", 64'(bus.RD1D), 64'hDEAD_BEEF);

        bus.FlushD = 1'b1;
        q.push_back(nop_exp());
        tick("flush_stall");
        bus.FlushD = 1'b0;
        bus.StallD = 1'b0;

        drive(ORI_M1, 32'h200, mk(32'h200, c(1, 0, 0, 0, 1, 3'b011, 2'b00, 2'b00),
                                  5'd1, 5'd1, 5'd31, 32'hFFFF_FFFF));
        tick("ori");
        drive(ADDI_NG, 32'h204, mk(32'h204, c(1, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00),
                                   5'd1, 5'd0, 5'd0, 32'hFFFF_FC00));
        tick("addi_f7");
        drive(SUB_I, 32'h208, mk(32'h208, c(1, 0, 0, 0, 0, 3'b001, 2'b00, 2'b00),
                                 5'd1, 5'd2, 5'd3, 32'h403));
        tick("sub");
        drive(SLT_I, 32'h20C, mk(32'h20C, c(1, 0, 0, 0, 0, 3'b101, 2'b00, 2'b00),
                                 5'd4, 5'd1, 5'd2, 32'h2));
        tick("slt");
        drive(AND_I, 32'h210, mk(32'h210, c(1, 0, 0, 0, 0, 3'b010, 2'b00, 2'b00),
                                 5'd1, 5'd2, 5'd3, 32'h3));
        tick("and");
        drive(BEQ_M4, 32'h214, mk(32'h214, c(0, 0, 0, 1, 0, 3'b001, 2'b00, 2'b10),
                                  5'd29, 5'd0, 5'd0, 32'hFFFF_FFFC));
        tick("beq");
        drive(JAL_0, 32'h218, mk(32'h218, c(1, 0, 1, 0, 0, 3'b000, 2'b10, 2'b11),
                                 5'd0, 5'd0, 5'd0, 32'h0));
        tick("jal");
        drive(BAD_OP, 32'h21C, mk(32'h21C, c(0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00),
                                  5'd0, 5'd0, 5'd0, 32'h0));
        tick("illegal");
`ifdef ILLEGAL_OPCODE_EN
        chk("illegal_d", 64'(bus.IllegalD), 64'd1);
`endif
        drive(SW_I, 32'h220, mk(32'h220, c(0, 1, 0, 0, 1, 3'b000, 2'b00, 2'b01),
                                5'd8, 5'd2, 5'd5, 32'd8));
        tick("sw");
`ifdef ILLEGAL_OPCODE_EN
        chk("illegal_clr", 64'(bus.IllegalD), 64'd0);
        chk("illegal_seen", 64'(bus.IllegalSeen), 64'd1);
`endif

        // Mid-run reset clears the register file on the same edge.
        reset = 1'b1;
        drive(ADD_X3, 32'h300, nop_exp());
        tick("reset_mid");
`ifdef ILLEGAL_OPCODE_EN
        chk("seen_reset", 64'(bus.IllegalSeen), 64'd0);
`endif
        reset = 1'b0;
        drive(ADD_X3, 32'h304, add_exp(32'h304));
        tick("add_after_rst");
        chk("x3_cleared", 64'(bus.RD1D), 64'h0);
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
